// File: rtl/tester_intr_pkg.sv
// Shared definitions for the TesterHW AXI-Lite interrupt controller.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package tester_intr_pkg;

    // Byte offsets of the register map (compared against a word-aligned address)
    localparam logic [31:0] GIE_OFS  = 32'h00;
    localparam logic [31:0] IER_OFS  = 32'h04;
    localparam logic [31:0] ISR_OFS  = 32'h08;
    localparam logic [31:0] IAR_OFS  = 32'h0C;
    localparam logic [31:0] IPR_OFS  = 32'h10;
    localparam logic [31:0] MODE_OFS = 32'h14;
    localparam logic [31:0] ISET_OFS = 32'h18;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        INTR_LEVEL = 1'b0,
        INTR_EDGE  = 1'b1
    } intr_mode_e;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/tester_intr_ctrl_axil_if.sv
// AXI4-Lite slave bus bundle for the interrupt controller register port.
// Latency: none (wiring only).
// Backpressure: carried by the standard valid/ready pairs on each channel.
interface tester_intr_ctrl_axil_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/tester_intr_sync_edge.sv
// Per-source metastability synchroniser followed by a rising-edge detector.
// Latency: sync_o follows src_i after C_SYNC_STAGES clocks; edge_o is high for the first synced-high cycle.
// Backpressure: none; free-running sampler.
module tester_intr_sync_edge #(
    parameter int C_SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic src_i,
    output logic sync_o,
    output logic edge_o
);

    logic [C_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                     sync_dly_q;

    // Shift the raw source into the synchroniser chain
    always_comb begin
        sync_d = {sync_q[C_SYNC_STAGES-2:0], src_i};
    end

    // Synchroniser flops plus one delayed copy of the synced level for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sync_dly_q <= sync_q[C_SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[C_SYNC_STAGES-1];
    assign edge_o = sync_q[C_SYNC_STAGES-1] & ~sync_dly_q;

endmodule

// File: rtl/tester_intr_ctrl_axil.sv
// Multi-source AXI4-Lite interrupt controller: per-channel edge/level capture, mask, ack, software set.
// Latency: irq_src -> irq is C_SYNC_STAGES + 2 clocks; AXI write B and read R arrive 2 clocks after valid.
// Backpressure: one write and one read outstanding; awready/arready held off while bvalid/rvalid wait.
module tester_intr_ctrl_axil #(
    parameter int C_NUM_IRQ          = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter bit C_IRQ_ACTIVE_STATE = 1'b1,
    parameter int C_SYNC_STAGES      = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [C_NUM_IRQ-1:0] irq_src,
    output logic                 irq,
    tester_intr_ctrl_axil_if.slave s_axi
);
    import tester_intr_pkg::*;

    localparam int N = C_NUM_IRQ;

    // Register state
    logic         gie_q, gie_d;
    logic [N-1:0] ier_q, ier_d;
    logic [N-1:0] mode_q, mode_d;
    logic [N-1:0] isr_q, isr_d;
    logic         irq_q, irq_d;

    // AXI channel state
    logic         awready_q, awready_d;
    logic         bvalid_q, bvalid_d;
    logic         arready_q, arready_d;
    logic         rvalid_q, rvalid_d;
    logic [31:0]  rdata_q, rdata_d;

    // Source path
    logic [N-1:0] src_sync, src_edge, src_set;

    // Write decode
    logic         wr_en, rd_en;
    logic [31:0]  wr_addr, rd_addr, wr_mask, wr_bits;
    logic [N-1:0] iar_clr, iset_bits;
    logic         unused_bits;

    for (genvar i = 0; i < N; i++) begin : g_src
        tester_intr_sync_edge #(
            .C_SYNC_STAGES (C_SYNC_STAGES)
        ) u_sync_edge (
            .clk_i   (ACLK),
            .rst_n_i (ARESETN),
            .src_i   (irq_src[i]),
            .sync_o  (src_sync[i]),
            .edge_o  (src_edge[i])
        );
    end

    // The master holds both valids until it sees the shared ready, so the handshake edge is the write edge
    assign wr_en   = awready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_en   = arready_q && s_axi.arvalid;
    assign wr_addr = 32'(s_axi.awaddr) & ~32'h3;
    assign rd_addr = 32'(s_axi.araddr) & ~32'h3;
    assign wr_mask = strb_to_mask(s_axi.wstrb);
    assign wr_bits = s_axi.wdata & wr_mask;
    assign unused_bits = ^{wr_bits, wr_mask};

    // Register writes honour byte strobes; IAR and ISET only produce one-cycle clear/set pulses
    always_comb begin
        gie_d     = gie_q;
        ier_d     = ier_q;
        mode_d    = mode_q;
        iar_clr   = '0;
        iset_bits = '0;
        if (wr_en) begin
            case (wr_addr)
                GIE_OFS:  if (s_axi.wstrb[0]) gie_d = s_axi.wdata[0];
                IER_OFS:  ier_d  = (ier_q  & ~wr_mask[N-1:0]) | wr_bits[N-1:0];
                MODE_OFS: mode_d = (mode_q & ~wr_mask[N-1:0]) | wr_bits[N-1:0];
                IAR_OFS:  iar_clr   = wr_bits[N-1:0];
                ISET_OFS: iset_bits = wr_bits[N-1:0];
                default:  ;
            endcase
        end
    end

    // Status capture: set (source or software) beats ack, so a still-high level source re-latches
    always_comb begin
        src_set = '0;
        for (int i = 0; i < N; i++) begin
            src_set[i] = (intr_mode_e'(mode_q[i]) == INTR_EDGE) ? src_edge[i] : src_sync[i];
        end
        isr_d = (isr_q & ~iar_clr) | src_set | iset_bits;
        irq_d = (gie_q && |(isr_q & ier_q)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
    end

    // AXI handshakes and registered read data; the read mux samples pre-write register values
    always_comb begin
        awready_d = !awready_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
        bvalid_d  = bvalid_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        arready_d = !arready_q && s_axi.arvalid && !rvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            case (rd_addr)
                GIE_OFS:  rdata_d = {31'b0, gie_q};
                IER_OFS:  rdata_d = 32'(ier_q);
                ISR_OFS:  rdata_d = 32'(isr_q);
                IPR_OFS:  rdata_d = 32'(isr_q & ier_q);
                MODE_OFS: rdata_d = 32'(mode_q);
                default:  rdata_d = 32'h0;
            endcase
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State register for the whole controller; reset aborts any transaction in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gie_q     <= 1'b0;
            ier_q     <= '0;
            mode_q    <= '0;
            isr_q     <= '0;
            irq_q     <= ~C_IRQ_ACTIVE_STATE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            gie_q     <= gie_d;
            ier_q     <= ier_d;
            mode_q    <= mode_d;
            isr_q     <= isr_d;
            irq_q     <= irq_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;
    assign s_axi.rvalid  = rvalid_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_tester_intr_ctrl_axil.sv
`timescale 1ns/1ps
module tb_tester_intr_ctrl_axil;

    localparam int          N     = 4;
    localparam int          TMO   = 50;
    localparam logic [31:0] NMASK = 32'hF;

    localparam logic [4:0] A_GIE  = 5'h00;
    localparam logic [4:0] A_IER  = 5'h04;
    localparam logic [4:0] A_ISR  = 5'h08;
    localparam logic [4:0] A_IAR  = 5'h0C;
    localparam logic [4:0] A_IPR  = 5'h10;
    localparam logic [4:0] A_MODE = 5'h14;
    localparam logic [4:0] A_ISET = 5'h18;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [N-1:0] irq_src;
    logic         irq;

    tester_intr_ctrl_axil_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    tester_intr_ctrl_axil #(
        .C_NUM_IRQ          (N),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_S_AXI_DATA_WIDTH (32),
        .C_IRQ_ACTIVE_STATE (1'b1),
        .C_SYNC_STAGES      (2)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .irq_src (irq_src),
        .irq     (irq),
        .s_axi   (bus)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents and the current source levels
    logic [31:0] m_gie, m_ier, m_mode, m_isr, m_src;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        if (s[0]) m = m | 32'h0000_00FF;
        if (s[1]) m = m | 32'h0000_FF00;
        if (s[2]) m = m | 32'h00FF_0000;
        if (s[3]) m = m | 32'hFF00_0000;
        return m;
    endfunction

    task automatic model_reset();
        m_gie = 0; m_ier = 0; m_mode = 0; m_isr = 0;
    endtask

    // Any channel in level mode whose source is high keeps its status bit set
    task automatic model_level();
        m_isr = m_isr | (m_src & ~m_mode & NMASK);
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = bytemask(s) & NMASK;
        case (a)
            A_GIE:  if (s[0]) m_gie = {31'b0, d[0]};
            A_IER:  m_ier  = (m_ier  & ~bm) | (d & bm);
            A_MODE: m_mode = (m_mode & ~bm) | (d & bm);
            A_IAR:  m_isr  = m_isr & ~(d & bm);
            A_ISET: m_isr  = m_isr | (d & bm);
            default: ;
        endcase
        model_level();
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            A_GIE:  return m_gie;
            A_IER:  return m_ier;
            A_ISR:  return m_isr;
            A_IPR:  return m_isr & m_ier;
            A_MODE: return m_mode;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_irq();
        return ((m_gie[0] == 1'b1) && ((m_isr & m_ier & NMASK) != 0)) ? 32'h1 : 32'h0;
    endfunction

    // Address+data phase up to and including the handshake edge; B channel left pending
    task automatic axi_write_start(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < TMO) begin
            tick(1);
            n++;
        end
        check("aw_timeout", 32'(n >= TMO), 32'h0);
        check("wready_pulse", 32'(bus.wready), 32'h1);
        tick(1);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic axi_write_finish();
        int n;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < TMO) begin
            tick(1);
            n++;
        end
        check("b_timeout", 32'(n >= TMO), 32'h0);
        check("bresp", 32'(bus.bresp), 32'h0);
        bus.bready = 1'b1;
        tick(1);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < TMO) begin
            tick(1);
            n++;
        end
        check("ar_timeout", 32'(n >= TMO), 32'h0);
        tick(1);
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < TMO) begin
            tick(1);
            n++;
        end
        check("r_timeout", 32'(n >= TMO), 32'h0);
        check("rresp", 32'(bus.rresp), 32'h0);
        // Stall the R channel a little; data must still be the captured value afterwards
        tick($urandom_range(3, 0));
        check("rvalid_held", 32'(bus.rvalid), 32'h1);
        d = bus.rdata;
        bus.rready = 1'b1;
        tick(1);
        bus.rready = 1'b0;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        axi_write_start(a, d, s);
        axi_write_finish();
        model_write(a, d, s);
        tick(6);
    endtask

    task automatic reg_check(input logic [4:0] a, input string tag);
        logic [31:0] v;
        axi_read(a, v);
        check(tag, v, model_read(a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] nsrc;
        int lat;
        int bad_b;
        int bad_aw;

        ARESETN     = 1'b0;
        irq_src     = '0;
        bus.awaddr  = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid  = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        m_src       = 0;
        model_reset();

        // 1. Reset values
        #1;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_awready", 32'(bus.awready), 32'h0);
        check("rst_arready", 32'(bus.arready), 32'h0);
        check("rst_bvalid", 32'(bus.bvalid), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        #22;
        ARESETN = 1'b1;
        tick(2);
        for (int k = 0; k < 8; k++) begin
            axi_read(5'(k * 4), v);
            check("rst_reg", v, 32'h0);
        end
        check("rst_irq_after", 32'(irq), 32'h0);

        // 2. Edge source, latency and ack
        reg_write(A_GIE, 32'h1, 4'hF);
        reg_write(A_IER, 32'h1, 4'hF);
        reg_write(A_MODE, 32'h1, 4'hF);
        irq_src[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            irq_src[0] = 1'b0;
            if (lat == 0 && irq === 1'b1) lat = k;
        end
        m_isr = m_isr | 32'h1;
        check("irq_latency", 32'(lat), 32'd4);
        reg_check(A_IPR, "ipr_edge");
        reg_write(A_IAR, 32'h1, 4'hF);
        check("irq_after_ack", 32'(irq), exp_irq());
        reg_check(A_IPR, "ipr_after_ack");

        // 3. Level source re-latches after ack while held high
        reg_write(A_MODE, 32'h0, 4'hF);
        reg_write(A_IER, 32'h2, 4'hF);
        irq_src[1] = 1'b1;
        m_src = 32'h2;
        model_level();
        tick(6);
        reg_check(A_ISR, "isr_level");
        check("irq_level", 32'(irq), exp_irq());
        reg_write(A_IAR, 32'h2, 4'hF);
        reg_check(A_ISR, "isr_relatch");
        check("irq_level_held", 32'(irq), exp_irq());
        irq_src[1] = 1'b0;
        m_src = 0;
        tick(6);
        check("irq_level_latched", 32'(irq), exp_irq());
        reg_write(A_IAR, 32'h2, 4'hF);
        check("irq_level_cleared", 32'(irq), exp_irq());
        reg_check(A_ISR, "isr_level_cleared");

        // 4. Software set and masking
        reg_write(A_IER, 32'h0, 4'hF);
        reg_write(A_ISET, 32'h8, 4'hF);
        reg_check(A_ISR, "isr_iset");
        reg_check(A_IPR, "ipr_masked");
        check("irq_masked", 32'(irq), exp_irq());
        reg_write(A_IER, 32'h8, 4'hF);
        check("irq_unmasked", 32'(irq), exp_irq());
        reg_write(A_IAR, 32'h8, 4'hF);

        // 5. Ack on the same edge as a source edge: set wins
        reg_write(A_MODE, 32'h1, 4'hF);
        reg_write(A_IER, 32'h1, 4'hF);
        reg_write(A_ISET, 32'h1, 4'hF);
        irq_src[0] = 1'b1;
        tick(1);
        axi_write_start(A_IAR, 32'h1, 4'hF);
        axi_write_finish();
        irq_src[0] = 1'b0;
        tick(4);
        reg_check(A_ISR, "isr_set_wins");
        check("irq_set_wins", 32'(irq), exp_irq());
        reg_write(A_IAR, 32'h1, 4'hF);
        reg_check(A_ISR, "isr_clear_after");

        // 6. Held B response blocks a second write; concurrent read sees pre-write value
        reg_write(A_ISET, 32'h1, 4'hF);
        fork
            axi_write_start(A_ISET, 32'h4, 4'hF);
            axi_read(A_ISR, v);
        join
        check("isr_concurrent_prewrite", v, m_isr);
        model_write(A_ISET, 32'h4, 4'hF);
        check("bresp_held", 32'(bus.bresp), 32'h0);
        bus.awaddr  = A_IAR;
        bus.wdata   = 32'h4;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bad_b  = 0;
        bad_aw = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (bus.bvalid !== 1'b1) bad_b++;
            if (bus.awready !== 1'b0) bad_aw++;
        end
        check("bvalid_held_cycles_bad", 32'(bad_b), 32'h0);
        check("awready_blocked_cycles_bad", 32'(bad_aw), 32'h0);
        bus.bready = 1'b1;
        tick(1);
        bus.bready = 1'b0;
        axi_write_start(A_IAR, 32'h4, 4'hF);
        axi_write_finish();
        model_write(A_IAR, 32'h4, 4'hF);
        tick(6);
        reg_check(A_ISR, "isr_after_second_write");
        reg_check(A_IPR, "ipr_after_second_write");

        // Randomised traffic against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(2, 0))
                0: reg_write(5'($urandom_range(7, 0) * 4), $urandom, 4'($urandom_range(15, 0)));
                1: begin
                    nsrc = 32'($urandom_range(15, 0));
                    m_isr = m_isr | (nsrc & ~m_src & m_mode & NMASK);
                    m_src = nsrc;
                    irq_src = nsrc[N-1:0];
                    model_level();
                    tick(6);
                end
                default: reg_check(5'($urandom_range(7, 0) * 4), "rand_read");
            endcase
            check("rand_irq", 32'(irq), exp_irq());
        end

        // Reset in the middle of a write aborts it
        irq_src = '0;
        m_src = 0;
        tick(6);
        reg_write(A_GIE, 32'h1, 4'hF);
        reg_write(A_IER, 32'hF, 4'hF);
        reg_write(A_ISET, 32'h2, 4'hF);
        check("irq_before_reset", 32'(irq), exp_irq());
        axi_write_start(A_MODE, 32'hF, 4'hF);
        #2;
        ARESETN = 1'b0;
        #1;
        model_reset();
        check("midrst_bvalid", 32'(bus.bvalid), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        tick(2);
        ARESETN = 1'b1;
        tick(2);
        reg_check(A_GIE, "post_rst_gie");
        reg_check(A_ISR, "post_rst_isr");
        reg_check(A_MODE, "post_rst_mode");
        check("post_rst_irq", 32'(irq), exp_irq());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
